// File: rtl/exception_unit_if.sv
// Pipeline/CP0 side of the exception unit: commit-stage fault flags in,
// CP0 capture strobes and flush/redirect control out.
interface exception_unit_if;
    logic        commit_valid;
    logic [31:0] commit_pc;
    logic        in_delay;
    logic        f_adel_if;
    logic        f_ri;
    logic        f_sys;
    logic        f_bp;
    logic        f_ov;
    logic        f_adel_mem;
    logic        f_ades_mem;
    logic [31:0] vaddr_mem;
    logic        eret;
    logic [5:0]  irq;
    logic [31:0] status_in;
    logic [31:0] epc_in;
    logic        except;
    logic [31:0] pc;
    logic [31:0] cause;
    logic [31:0] state;
    logic [31:0] badAddress;
    logic        status_we;
    logic [31:0] status_wdata;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport slave (
        input  commit_valid, commit_pc, in_delay,
        input  f_adel_if, f_ri, f_sys, f_bp, f_ov, f_adel_mem, f_ades_mem,
        input  vaddr_mem, eret, irq, status_in, epc_in,
        output except, pc, cause, state, badAddress,
        output status_we, status_wdata, flush, redirect, redirect_pc
    );

    modport master (
        output commit_valid, commit_pc, in_delay,
        output f_adel_if, f_ri, f_sys, f_bp, f_ov, f_adel_mem, f_ades_mem,
        output vaddr_mem, eret, irq, status_in, epc_in,
        input  except, pc, cause, state, badAddress,
        input  status_we, status_wdata, flush, redirect, redirect_pc
    );
endinterface

// File: rtl/exception_unit.sv
// Picks one exception/interrupt winner at the MEM commit point, captures it for CP0,
// then holds flush and redirects to the vector (or to EPC on ERET).
module exception_unit #(
    parameter logic [31:0] VECTOR       = 32'hBFC0_0380,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic CLK,
    input  logic RST,
    exception_unit_if.slave bus
);
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, EXC, RET} fsm_t;

    fsm_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic        last_cycle;
    logic [5:0]  irq_meta_reg, irq_sync_reg;
    logic        exl_reg;
    logic        int_req;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] bad_next;
    logic        bd;

    logic [31:0] pc_reg, cause_reg, state_out_reg, bad_reg, status_wdata_reg, redirect_pc_reg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            irq_meta_reg <= '0;
            irq_sync_reg <= '0;
        end else begin
            irq_meta_reg <= bus.irq;
            irq_sync_reg <= irq_meta_reg;
        end
    end

    // exl_reg covers the window before CP0's Status reflects the EXL we just requested.
    assign int_req = (|(irq_sync_reg & bus.status_in[15:10])) & bus.status_in[0]
                   & ~(bus.status_in[1] | exl_reg);
    assign bd      = bus.commit_valid & bus.in_delay;

    always_comb begin
        exc_req  = 1'b0;
        exc_code = 5'd0;
        bad_next = 32'h0;
        if (int_req) begin
            exc_req  = 1'b1;
            exc_code = 5'd0;
        end else if (bus.commit_valid) begin
            if (bus.f_adel_if) begin
                exc_req = 1'b1; exc_code = 5'd4;  bad_next = bus.commit_pc;
            end else if (bus.f_ri) begin
                exc_req = 1'b1; exc_code = 5'd10;
            end else if (bus.f_sys) begin
                exc_req = 1'b1; exc_code = 5'd8;
            end else if (bus.f_bp) begin
                exc_req = 1'b1; exc_code = 5'd9;
            end else if (bus.f_ov) begin
                exc_req = 1'b1; exc_code = 5'd12;
            end else if (bus.f_adel_mem) begin
                exc_req = 1'b1; exc_code = 5'd4;  bad_next = bus.vaddr_mem;
            end else if (bus.f_ades_mem) begin
                exc_req = 1'b1; exc_code = 5'd5;  bad_next = bus.vaddr_mem;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign last_cycle = (cnt_reg == CW'(FLUSH_CYCLES - 1));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (exc_req)
                    state_next = EXC;
                else if (bus.commit_valid && bus.eret)
                    state_next = RET;
            end
            default: begin
                if (last_cycle) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
        endcase
    end

    always_comb begin
        bus.except    = (state_reg == EXC) && (cnt_reg == '0);
        bus.status_we = (state_reg == RET) && (cnt_reg == '0);
        bus.flush     = (state_reg != IDLE);
        bus.redirect  = (state_reg != IDLE) && last_cycle;
    end

    // Capture data is only loaded on the IDLE exit edge, so it holds between strobes.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            exl_reg          <= 1'b0;
            pc_reg           <= '0;
            cause_reg        <= '0;
            state_out_reg    <= '0;
            bad_reg          <= '0;
            status_wdata_reg <= '0;
            redirect_pc_reg  <= '0;
        end else if (state_reg == IDLE) begin
            if (exc_req) begin
                exl_reg         <= 1'b1;
                pc_reg          <= bd ? (bus.commit_pc - 32'd4) : bus.commit_pc;
                cause_reg       <= {bd, 15'b0, irq_sync_reg, 3'b0, exc_code, 2'b0};
                state_out_reg   <= bus.status_in | 32'h2;
                bad_reg         <= bad_next;
                redirect_pc_reg <= VECTOR;
            end else if (bus.commit_valid && bus.eret) begin
                exl_reg          <= 1'b0;
                status_wdata_reg <= bus.status_in & ~32'h2;
                redirect_pc_reg  <= bus.epc_in;
            end
        end
    end

    assign bus.pc           = pc_reg;
    assign bus.cause        = cause_reg;
    assign bus.state        = state_out_reg;
    assign bus.badAddress   = bad_reg;
    assign bus.status_wdata = status_wdata_reg;
    assign bus.redirect_pc  = redirect_pc_reg;
endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit: hand-computed expectations checked with immediate assertions.
module tb_exception_unit;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    exception_unit_if u_if ();

    exception_unit #(
        .VECTOR       (32'hBFC0_0380),
        .FLUSH_CYCLES (3)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_commit();
        u_if.commit_valid = 1'b0;
        u_if.in_delay     = 1'b0;
        u_if.f_adel_if    = 1'b0;
        u_if.f_ri         = 1'b0;
        u_if.f_sys        = 1'b0;
        u_if.f_bp         = 1'b0;
        u_if.f_ov         = 1'b0;
        u_if.f_adel_mem   = 1'b0;
        u_if.f_ades_mem   = 1'b0;
        u_if.eret         = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        clear_commit();
        u_if.commit_pc = 32'h0;
        u_if.vaddr_mem = 32'h0;
        u_if.irq       = 6'b0;
        u_if.status_in = 32'h0;
        u_if.epc_in    = 32'h0;

        tick(); tick();
        check1 ("rst_except",   u_if.except,   1'b0);
        check1 ("rst_flush",    u_if.flush,    1'b0);
        check1 ("rst_redirect", u_if.redirect, 1'b0);
        check32("rst_pc",       u_if.pc,       32'h0);
        rst = 1'b1;
        tick();

        // Overflow, no delay slot
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h100; u_if.f_ov = 1'b1;
        tick();
        clear_commit();
        check1 ("ov_except", u_if.except, 1'b1);
        check32("ov_pc",     u_if.pc,     32'h100);
        check32("ov_cause",  u_if.cause,  32'h30);
        check32("ov_state",  u_if.state,  32'h2);
        check32("ov_bad",    u_if.badAddress, 32'h0);
        check1 ("ov_flush1", u_if.flush,  1'b1);
        check1 ("ov_redir1", u_if.redirect, 1'b0);
        tick();
        check1 ("ov_except2", u_if.except, 1'b0);
        check1 ("ov_flush2",  u_if.flush,  1'b1);
        check1 ("ov_redir2",  u_if.redirect, 1'b0);
        tick();
        check1 ("ov_redir3",  u_if.redirect, 1'b1);
        check32("ov_rpc",     u_if.redirect_pc, 32'hBFC0_0380);
        tick();
        check1 ("ov_flush4",  u_if.flush, 1'b0);
        check1 ("ov_redir4",  u_if.redirect, 1'b0);
        check32("ov_pc_hold", u_if.pc, 32'h100);

        // Load address error in a delay slot
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h204; u_if.in_delay = 1'b1;
        u_if.f_adel_mem = 1'b1; u_if.vaddr_mem = 32'h1003;
        tick();
        clear_commit();
        check1 ("adel_except", u_if.except, 1'b1);
        check32("adel_pc",     u_if.pc,     32'h200);
        check32("adel_cause",  u_if.cause,  32'h8000_0010);
        check32("adel_bad",    u_if.badAddress, 32'h1003);
        tick(); tick(); tick();

        // Fetch AdEL beats syscall; delay slot at PC 0 wraps
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h0; u_if.in_delay = 1'b1;
        u_if.f_adel_if = 1'b1; u_if.f_sys = 1'b1; u_if.vaddr_mem = 32'h5555;
        tick();
        clear_commit();
        check32("aif_pc",    u_if.pc,    32'hFFFF_FFFC);
        check32("aif_cause", u_if.cause, 32'h8000_0010);
        check32("aif_bad",   u_if.badAddress, 32'h0);
        tick(); tick(); tick();

        // RI beats Ov
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h140; u_if.f_ri = 1'b1; u_if.f_ov = 1'b1;
        tick();
        clear_commit();
        check32("ri_cause", u_if.cause, 32'h28);
        check32("ri_bad",   u_if.badAddress, 32'h0);
        tick(); tick(); tick();

        // ERET: EPC sampled on the request cycle
        u_if.commit_valid = 1'b1; u_if.eret = 1'b1; u_if.epc_in = 32'h400; u_if.status_in = 32'h403;
        tick();
        clear_commit();
        u_if.epc_in = 32'h999;
        check1 ("eret_we",     u_if.status_we, 1'b1);
        check32("eret_wdata",  u_if.status_wdata, 32'h401);
        check1 ("eret_except", u_if.except, 1'b0);
        check1 ("eret_flush",  u_if.flush, 1'b1);
        tick();
        check1 ("eret_we2",    u_if.status_we, 1'b0);
        tick();
        check1 ("eret_redir",  u_if.redirect, 1'b1);
        check32("eret_rpc",    u_if.redirect_pc, 32'h400);
        tick();
        check1 ("eret_flush4", u_if.flush, 1'b0);

        // Interrupt through the synchroniser, no valid commit
        u_if.status_in = 32'h401; u_if.commit_pc = 32'h300; u_if.irq = 6'b000001;
        tick();
        check1 ("irq_e1", u_if.except, 1'b0);
        tick();
        check1 ("irq_e2", u_if.except, 1'b0);
        tick();
        check1 ("irq_e3",    u_if.except, 1'b1);
        check32("irq_cause", u_if.cause, 32'h400);
        check32("irq_pc",    u_if.pc,    32'h300);
        check32("irq_state", u_if.state, 32'h403);
        tick(); tick(); tick();

        // ERET with IE=0: pending irq must stay masked
        u_if.status_in = 32'h400;
        u_if.commit_valid = 1'b1; u_if.eret = 1'b1; u_if.epc_in = 32'h310;
        tick();
        clear_commit();
        check1 ("ie0_we", u_if.status_we, 1'b1);
        tick(); tick(); tick();
        for (int i = 0; i < 4; i++) begin
            check1("ie0_noexc", u_if.except | u_if.flush, 1'b0);
            tick();
        end
        u_if.irq = 6'b0;
        tick(); tick();

        // ERET together with RI: the exception wins
        u_if.commit_valid = 1'b1; u_if.eret = 1'b1; u_if.f_ri = 1'b1; u_if.commit_pc = 32'h500;
        tick();
        clear_commit();
        check1 ("eri_except", u_if.except, 1'b1);
        check1 ("eri_we",     u_if.status_we, 1'b0);
        check32("eri_cause",  u_if.cause, 32'h28);
        tick(); tick();
        check32("eri_rpc",    u_if.redirect_pc, 32'hBFC0_0380);
        tick();

        // Second fault during flush ignored; async reset aborts
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h600; u_if.f_bp = 1'b1;
        tick();
        clear_commit();
        check32("bp_cause", u_if.cause, 32'h24);
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h700; u_if.f_sys = 1'b1;
        tick();
        clear_commit();
        check1 ("ign_except", u_if.except, 1'b0);
        check32("ign_pc",     u_if.pc, 32'h600);
        #2 rst = 1'b0;
        #1;
        check1 ("arst_flush",  u_if.flush, 1'b0);
        check1 ("arst_redir",  u_if.redirect, 1'b0);
        check32("arst_pc",     u_if.pc, 32'h0);
        check32("arst_cause",  u_if.cause, 32'h0);
        check32("arst_rpc",    u_if.redirect_pc, 32'h0);
        #2 rst = 1'b1;
        u_if.commit_valid = 1'b1; u_if.commit_pc = 32'h700; u_if.f_sys = 1'b1;
        tick();
        clear_commit();
        check1 ("post_except", u_if.except, 1'b1);
        check32("post_pc",     u_if.pc, 32'h700);
        check32("post_cause",  u_if.cause, 32'h20);
        tick(); tick();
        check1 ("post_redir",  u_if.redirect, 1'b1);
        tick();
        check1 ("post_idle",   u_if.flush, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
